// File: rtl/ibuf2ddr_pkg.sv
// rtl/ibuf2ddr_pkg.sv - shared global parameters, width helper and index-buffer transfer types
//
// Holds the system-wide DDR beat width and index width, the bw() address-width
// helper, the ibuf2ddr FSM state type and idx_batch(), which is also used by the
// DDR-to-index-buffer loader so both sides agree on beat packing.
package ibuf2ddr_pkg;

    localparam int DDR_W = 512;
    localparam int IDX_W = 16;

    // Bits needed to address x entries (minimum 1).
    function automatic int bw(input int x);
        return (x <= 2) ? 1 : $clog2(x);
    endfunction

    // Index pairs packed into one DDR beat.
    function automatic int idx_batch();
        return DDR_W / (IDX_W * 2);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } ibuf2ddr_state_t;

endpackage

// File: rtl/ibuf2ddr.sv
// rtl/ibuf2ddr.sv - index buffer to DDR write-back packer
//
// Reads index pairs from the index buffer (1-cycle read latency), packs
// idx_batch() pairs per beat and streams beats toward DDR with valid/ready.
// Optional macro IBUF2DDR_STALL_CNT_EN adds a saturating backpressure counter.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   start / done     transfer start pulse (accepted in IDLE) / completion pulse
//   conf_idx_num     index of the last pair to send (latched on start)
//   idx_rd_en/addr   index buffer read request
//   idx_rd_data      read data, valid the cycle after idx_rd_en
//   ddr_data/valid   packed beat toward DDR
//   ddr_ready        downstream accept
//   stall_cnt        (IBUF2DDR_STALL_CNT_EN only) cycles of valid && !ready
module ibuf2ddr
    import ibuf2ddr_pkg::*;
#(
    parameter int IDX_DEPTH = 256,
    parameter int ADDR_W    = bw(IDX_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 done,
    input  logic [7:0]           conf_idx_num,
    output logic                 idx_rd_en,
    output logic [ADDR_W-1:0]    idx_rd_addr,
    input  logic [IDX_W*2-1:0]   idx_rd_data,
    output logic [DDR_W-1:0]     ddr_data,
    output logic                 ddr_valid,
    input  logic                 ddr_ready
`ifdef IBUF2DDR_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int PAIR_W    = IDX_W * 2;
    localparam int IDX_BATCH = idx_batch();
    localparam int LANE_W    = bw(IDX_BATCH);

    ibuf2ddr_state_t r_state;
    ibuf2ddr_state_t w_state_nxt;

    logic [7:0]        r_conf;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [LANE_W-1:0] r_rd_lane;    // lane of the next read in this beat
    logic [LANE_W-1:0] r_lane_cnt;   // lane the next returned word lands in
    logic              r_rd_valid;   // idx_rd_data carries a requested word
    logic              r_rd_stop;    // all reads for this beat issued
    logic              r_all_read;   // read of conf_idx_num has been issued
    logic [DDR_W-1:0]  r_pack;

    logic w_accept;
    logic w_rd_en;
    logic w_conf_hit;
    logic w_last_read;
    logic w_beat_acc;

    assign w_accept    = (r_state == IDLE) && start;
    assign w_rd_en     = (r_state == FILL) && !r_rd_stop;
    assign w_conf_hit  = (r_rd_cnt == ADDR_W'(r_conf));
    assign w_last_read = w_rd_en && (w_conf_hit || (r_rd_lane == LANE_W'(IDX_BATCH - 1)));
    assign w_beat_acc  = (r_state == SEND) && ddr_ready;

    assign idx_rd_en   = w_rd_en;
    assign idx_rd_addr = r_rd_cnt;
    assign ddr_valid   = (r_state == SEND);
    assign ddr_data    = r_pack;
    assign done        = (r_state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = FILL;
            // The stop flag is set together with the final read, so the
            // first valid return seen with it set is the beat's last word.
            FILL: if (r_rd_valid && r_rd_stop) w_state_nxt = SEND;
            SEND: if (ddr_ready) w_state_nxt = r_all_read ? DONE : FILL;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_conf     <= '0;
            r_rd_cnt   <= '0;
            r_rd_lane  <= '0;
            r_lane_cnt <= '0;
            r_rd_valid <= 1'b0;
            r_rd_stop  <= 1'b0;
            r_all_read <= 1'b0;
            r_pack     <= '0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_accept) begin
                r_conf     <= conf_idx_num;
                r_rd_cnt   <= '0;
                r_rd_lane  <= '0;
                r_lane_cnt <= '0;
                r_rd_stop  <= 1'b0;
                r_all_read <= 1'b0;
                r_pack     <= '0;
            end
            if (w_rd_en) begin
                r_rd_lane <= r_rd_lane + LANE_W'(1);
                // Hold the address on the final pair so it never wraps.
                if (!w_conf_hit) r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
                if (w_last_read) r_rd_stop <= 1'b1;
                if (w_conf_hit) r_all_read <= 1'b1;
            end
            if (r_rd_valid) begin
                r_pack[int'(r_lane_cnt) * PAIR_W +: PAIR_W] <= idx_rd_data;
                r_lane_cnt <= r_lane_cnt + LANE_W'(1);
            end
            if (w_beat_acc) begin
                r_pack     <= '0;
                r_lane_cnt <= '0;
                r_rd_lane  <= '0;
                r_rd_stop  <= 1'b0;
            end
        end
    end

`ifdef IBUF2DDR_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if (ddr_valid && !ddr_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ibuf2ddr.sv
// tb/tb_ibuf2ddr.sv - scoreboard testbench for ibuf2ddr
module tb_ibuf2ddr;
    import ibuf2ddr_pkg::*;

    localparam int ADDR_W = 8;
    localparam int PW     = IDX_W * 2;
    localparam int NB     = DDR_W / PW;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              done;
    logic [7:0]        conf_idx_num;
    logic              idx_rd_en;
    logic [ADDR_W-1:0] idx_rd_addr;
    logic [PW-1:0]     idx_rd_data;
    logic [DDR_W-1:0]  ddr_data;
    logic              ddr_valid;
    logic              ddr_ready;
`ifdef IBUF2DDR_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    ibuf2ddr #(.IDX_DEPTH(256), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .done         (done),
        .conf_idx_num (conf_idx_num),
        .idx_rd_en    (idx_rd_en),
        .idx_rd_addr  (idx_rd_addr),
        .idx_rd_data  (idx_rd_data),
        .ddr_data     (ddr_data),
        .ddr_valid    (ddr_valid),
        .ddr_ready    (ddr_ready)
`ifdef IBUF2DDR_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [PW-1:0] mem [256];
    always @(posedge clk) begin
        if (idx_rd_en) idx_rd_data <= mem[idx_rd_addr];
    end

    int n_vec = 0;
    int n_bad = 0;
    logic [DDR_W-1:0] exp_q [$];
    int n_beats, n_done, n_reads, n_rd_viol;
    int rd_hits [256];

    task automatic chk(input string tag, input logic [DDR_W-1:0] got, input logic [DDR_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (rst === 1'b1) begin
            if (ddr_valid && ddr_ready) begin
                if (exp_q.size() == 0) chk("beat_extra", 1, 0);
                else chk("beat", ddr_data, exp_q.pop_front());
                n_beats++;
            end
            if (done) n_done++;
            if (idx_rd_en) begin
                rd_hits[idx_rd_addr]++;
                n_reads++;
            end
            if (idx_rd_en && (ddr_valid || done)) n_rd_viol++;
        end
    end

    task automatic clear_stats();
        n_beats = 0; n_done = 0; n_reads = 0; n_rd_viol = 0;
        for (int i = 0; i < 256; i++) rd_hits[i] = 0;
    endtask

    task automatic push_expect(input int conf);
        logic [DDR_W-1:0] beat;
        for (int b = 0; b <= conf / NB; b++) begin
            beat = '0;
            for (int k = 0; k < NB; k++) begin
                if (b * NB + k <= conf) beat[k*PW +: PW] = mem[b*NB + k];
            end
            exp_q.push_back(beat);
        end
    endtask

    task automatic pulse_start(input int conf);
        @(negedge clk);
        conf_idx_num = 8'(conf);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0;
        bit seen;
        d0 = n_done;
        seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (n_done != d0) seen = 1;
        end
        if (!seen) chk({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic wait_valid(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (ddr_valid) seen = 1;
            else @(negedge clk);
        end
        if (!seen) chk({tag, "_valid_timeout"}, 0, 1);
    endtask

    task automatic finish_xfer(input string tag, input int beats);
        repeat (4) @(negedge clk);
        chk({tag, "_beats"}, n_beats, beats);
        chk({tag, "_done_cnt"}, n_done, 1);
        chk({tag, "_q_empty"}, exp_q.size(), 0);
        chk({tag, "_rd_in_send"}, n_rd_viol, 0);
    endtask

    initial begin
        int lat, bad_hits;
        logic [DDR_W-1:0] held;

        rst = 1'b0; start = 1'b0; conf_idx_num = '0; ddr_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = PW'(i);
        clear_stats();
        repeat (3) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_valid", ddr_valid, 0);
        chk("rst_rd_en", idx_rd_en, 0);
        chk("rst_rd_addr", idx_rd_addr, 0);
        chk("rst_data", ddr_data, 0);
        rst = 1'b1;
        @(negedge clk);

        // Two full beats, checking fill latency and read coverage.
        clear_stats();
        push_expect(31);
        conf_idx_num = 8'd31;
        start = 1'b1;
        lat = 0;
        for (int i = 0; i < 100 && !ddr_valid; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        chk("fill_latency", lat, NB + 2);
        wait_done("full");
        finish_xfer("full", 2);
        bad_hits = 0;
        for (int i = 0; i < 256; i++) if (rd_hits[i] != ((i < 32) ? 1 : 0)) bad_hits++;
        chk("full_rd_hits", bad_hits, 0);
        chk("full_rd_total", n_reads, 32);

        // Partial final beat.
        clear_stats();
        push_expect(20);
        pulse_start(20);
        wait_done("partial");
        finish_xfer("partial", 2);

        // Backpressure on beat 0.
        clear_stats();
        push_expect(31);
        ddr_ready = 1'b0;
        pulse_start(31);
        wait_valid("stall");
        held = ddr_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", ddr_valid, 1);
            chk("stall_data", ddr_data, held);
            chk("stall_rd_en", idx_rd_en, 0);
        end
        ddr_ready = 1'b1;
        wait_done("stall");
        finish_xfer("stall", 2);
`ifdef IBUF2DDR_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 10);
`endif

        // Single pair.
        clear_stats();
        mem[0] = 32'hDEADBEEF;
        push_expect(0);
        chk("single_model", exp_q[0], {{(DDR_W-32){1'b0}}, 32'hDEADBEEF});
        pulse_start(0);
        wait_done("single");
        finish_xfer("single", 1);

        // Start while busy is ignored, including its configuration.
        clear_stats();
        push_expect(31);
        pulse_start(31);
        repeat (3) @(negedge clk);
        conf_idx_num = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy");
        finish_xfer("busy", 2);

        // Reset during SEND.
        clear_stats();
        ddr_ready = 1'b0;
        pulse_start(31);
        wait_valid("rstmid");
        rst = 1'b0;
        #1;
        chk("rstmid_valid_drop", ddr_valid, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ddr_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("rstmid_no_done", n_done, 0);
        chk("rstmid_no_beat", n_beats, 0);
        clear_stats();
        push_expect(15);
        pulse_start(15);
        wait_done("after_rst");
        finish_xfer("after_rst", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ibuf2ddr.md
Name: ibuf2ddr

Overview:
- Transmit-side counterpart of the DDR-to-index-buffer loader.
- Reads index pairs out of an index buffer through a 1-cycle-latency read port.
- Packs IDX_BATCH pairs per beat into a DDR_W-wide data stream and drives it toward DDR with a valid/ready handshake.
- Sits between the PE-side index buffer and the DDR write-back stream; it is started and monitored by the layer controller via start/done.

Parameters:
- IDX_DEPTH, 256, index buffer depth in IDX_W*2-bit words.
- ADDR_W, bw(IDX_DEPTH), index buffer address width.
- (DDR_W and IDX_W come from GLOBAL_PARAM.)
- Derived localparam: IDX_BATCH = DDR_W/(IDX_W*2), pairs per beat, must be >= 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a transfer when idle.
- done  out  1  one-cycle pulse after the final beat handshakes.
- conf_idx_num  in  8  index of the last pair to send; pair count = conf_idx_num+1.
- idx_rd_en  out  1  buffer read enable.
- idx_rd_addr  out  ADDR_W  buffer read address.
- idx_rd_data  in  IDX_W*2  read data, valid the cycle after idx_rd_en.
- ddr_data  out  DDR_W  packed beat.
- ddr_valid  out  1  beat valid.
- ddr_ready  in  1  downstream accept.

Behaviour:
- Reset values (async on rst low): state IDLE; done=0, ddr_valid=0, idx_rd_en=0, idx_rd_addr=0, ddr_data=0, all counters 0.
- Configuration capture: conf_idx_num is latched on the accepted start. Changes to the input during a transfer are ignored.
- start while not IDLE: ignored.
- State IDLE: on start, clear rd_cnt and lane_cnt, clear the pack register, then go to FILL.
- State FILL:
  - Each cycle, issue idx_rd_en=1 with idx_rd_addr=rd_cnt; rd_cnt increments.
  - Reads stop after the lane IDX_BATCH-1 read or after the read of address conf_idx_num, whichever comes first.
  - Returned data is written into lane lane_cnt of the pack register one cycle later. Lane 0 occupies bits [IDX_W*2-1:0].
  - When the last requested read data is captured, go to SEND.
  - Lanes not written in a partial final beat are zero.
- State SEND:
  - ddr_valid=1, and ddr_data equals the pack register.
  - ddr_data must stay stable while ddr_valid && !ddr_ready.
  - On ddr_valid && ddr_ready: if pairs remain, clear the pack register and lane_cnt and go to FILL; otherwise go to DONE.
  - ddr_ready while ddr_valid=0 has no effect.
- State DONE: pulse done=1 for exactly one cycle, then go to IDLE.
- No reads are issued in SEND or DONE.
- Beats per transfer = ceil((conf_idx_num+1)/IDX_BATCH).
- Full beat latency: IDX_BATCH+1 cycles FILL, then SEND.
- Arithmetic: rd_cnt is ADDR_W bits wide; the comparison uses conf_idx_num zero-extended to ADDR_W. With IDX_DEPTH=256, conf_idx_num=255 sends the full buffer and never wraps.
- conf_idx_num=0: one beat, lane 0 only, all other lanes zero.
- rst asserted mid-transfer: immediate return to IDLE, ddr_valid drops asynchronously, no done pulse, and the partial beat is discarded.

Optional Feature:
- Macro: IBUF2DDR_STALL_CNT_EN.
- Defined:
  - Adds an output port stall_cnt, 16 bits.
  - It counts cycles with ddr_valid && !ddr_ready, saturating at 16'hFFFF.
  - It clears on an accepted start and resets to 0.
  - Its value holds after done until the next start.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- GLOBAL_PARAM supplies DDR_W, IDX_W and bw().
- Add to GLOBAL_PARAM:
  - the FSM state enum type ibuf2ddr_state_t (IDLE, FILL, SEND, DONE);
  - a function idx_batch() returning DDR_W/(IDX_W*2), shared with the loader.
- No sub-module: pack register, FSM and counters stay in one module.

Test Plan (DDR_W=512, IDX_W=16, IDX_BATCH=16):
- Full beats: buffer[i]=i, conf_idx_num=31, ddr_ready tied 1 -> exactly 2 beats. Beat0 lane k = k; beat1 lane k = 16+k. Single done pulse after beat1; idx_rd_addr covers 0..31 once each.
- Partial beat: conf_idx_num=20 -> 2 beats. Beat1 lanes 0..4 = 16..20, lanes 5..15 = 0.
- Backpressure: ddr_ready low for 10 cycles at beat0 -> ddr_valid held and ddr_data constant, no idx_rd_en during the stall. With IBUF2DDR_STALL_CNT_EN, stall_cnt=10 at done.
- Single pair: conf_idx_num=0, buffer[0]=32'hDEADBEEF -> one beat, ddr_data = 512-bit zero-extended 32'hDEADBEEF.
- Start while busy: second start pulse during FILL -> ignored, beat count unchanged, one done pulse.
- Reset mid-transfer: rst low during SEND -> ddr_valid=0 immediately. After rst high, no done pulse; a new start with conf_idx_num=15 produces a correct single beat.
